// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-side FIFO controllers.
package fifo_pkg;

    function automatic int fifo_depth(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after prio, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   prio,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        int         cand;
        logic [IDX_W-1:0] cand_idx;
        logic       found;
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand     = (int'(prio) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write side of an async FIFO: arbitrates several writers round-robin into
// the memory and maintains the Gray write pointer and conservative flags.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int AF_TH      = 2
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [PTR_WIDTH:0]            rptr_gray_sync,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          mem_wen,
    output logic [PTR_WIDTH-1:0]          mem_waddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [PTR_WIDTH:0]            wptr_gray,
    output logic                          wfull,
    output logic                          walmost_full,
    output logic [PTR_WIDTH:0]            wlevel
);

    localparam int DEPTH = fifo_depth(PTR_WIDTH);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH+1)'(DEPTH - AF_TH);

    logic [PTR_WIDTH:0]   wbin_q, wbin_d;
    logic [PTR_WIDTH:0]   wptr_gray_q, wptr_gray_d;
    logic [PTR_WIDTH:0]   wlevel_q, wlevel_d;
    logic                 wfull_q, wfull_d;
    logic                 walmost_full_q, walmost_full_d;
    logic [IDX_W-1:0]     prio_q, prio_d;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]   req_ok;
    logic [PTR_WIDTH:0]   rbin;
    logic                 wen;

    // Reset or full suppresses every request, so the arbiter never grants then.
    assign req_ok = (wfull_q || wrst) ? '0 : req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req    (req_ok),
        .prio   (prio_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign wen          = |gnt;
    assign mem_wen      = wen;
    assign mem_waddr    = wbin_q[PTR_WIDTH-1:0];
    assign mem_wdata    = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign wptr_gray    = wptr_gray_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;

    always_comb begin
        rbin        = (PTR_WIDTH+1)'(gray2bin(32'(rptr_gray_sync)));
        wbin_d      = wbin_q + {{PTR_WIDTH{1'b0}}, wen};
        wptr_gray_d = (PTR_WIDTH+1)'(bin2gray(32'(wbin_d)));
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        wfull_d = (wptr_gray_d == {~rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1],
                                   rptr_gray_sync[PTR_WIDTH-2:0]});
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= AF_LEVEL);
        prio_d         = prio_q;
        if (wen) begin
            prio_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_gray_q    <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            prio_q         <= '0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_gray_q    <= wptr_gray_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            prio_q         <= prio_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against an occupancy model.
module tb_fifo_write_arbiter;

    localparam int PW = 4;
    localparam int DW = 8;
    localparam int NR = 4;

    logic              wclk = 1'b0;
    logic              wrst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [PW:0]       rptr_gray_sync = '0;
    logic [NR-1:0]     gnt;
    logic              mem_wen;
    logic [PW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic [PW:0]       wptr_gray;
    logic              wfull;
    logic              walmost_full;
    logic [PW:0]       wlevel;

    int vectors = 0;
    int errors  = 0;

    // Model: write/read counts mod 32, occupancy, rotating priority.
    int            m_wbin = 0;
    int            m_rbin = 0;
    int            m_prio = 0;
    int            m_level = 0;
    logic          m_full = 1'b0;
    logic          m_af = 1'b0;
    logic [NR-1:0] exp_gnt;
    logic          exp_wen;
    int            exp_idx;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .PTR_WIDTH (PW),
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .AF_TH     (2)
    ) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .req           (req),
        .req_data      (req_data),
        .rptr_gray_sync(rptr_gray_sync),
        .gnt           (gnt),
        .mem_wen       (mem_wen),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .wptr_gray     (wptr_gray),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel)
    );

    function automatic logic [PW:0] to_gray(input int b);
        logic [PW:0] v;
        v = (PW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic model_comb();
        exp_gnt = '0;
        exp_wen = 1'b0;
        exp_idx = 0;
        if (!wrst && !m_full) begin
            for (int off = 0; off < NR; off++) begin
                int i;
                i = (m_prio + off) % NR;
                if (!exp_wen && req[i]) begin
                    exp_gnt[i] = 1'b1;
                    exp_wen    = 1'b1;
                    exp_idx    = i;
                end
            end
        end
    endtask

    task automatic model_clk();
        if (wrst) begin
            m_wbin = 0; m_prio = 0; m_level = 0; m_full = 1'b0; m_af = 1'b0;
        end else begin
            if (exp_wen) begin
                m_wbin = (m_wbin + 1) % 32;
                m_prio = (exp_idx + 1) % NR;
            end
            m_level = (m_wbin - m_rbin + 32) % 32;
            m_full  = (m_level == 16);
            m_af    = (m_level >= 14);
        end
    endtask

    task automatic drive(input logic [NR-1:0] r, input logic rst);
        req            = r;
        wrst           = rst;
        req_data       = $urandom;
        rptr_gray_sync = to_gray(m_rbin);
        model_comb();
    endtask

    task automatic adv();
        @(posedge wclk);
        model_clk();
        #1;
    endtask

    task automatic do_reset();
        m_rbin = 0;
        drive(NR'($urandom_range(0, 15)), 1'b1);
        adv();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        m_rbin = 0;
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, 1'b1);
            #3;
            vectors++;
            if (gnt !== 4'b0000 || mem_wen !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt: gnt=%b wen=%b want 0000/0", gnt, mem_wen);
            end
            adv();
            vectors++;
            if (wptr_gray !== 5'd0 || wfull !== 1'b0 || walmost_full !== 1'b0 ||
                wlevel !== 5'd0 || mem_waddr !== 4'd0) begin
                errors++;
                $display("FAIL reset_state: gray=%b full=%b af=%b level=%0d waddr=%0d want all 0",
                         wptr_gray, wfull, walmost_full, wlevel, mem_waddr);
            end
        end
        wrst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [NR-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0);
            #3;
            vectors++;
            if (gnt !== seq[i] || gnt !== exp_gnt || mem_waddr !== PW'(i)) begin
                errors++;
                $display("FAIL rotation_%0d: gnt=%b waddr=%0d want %b/%0d", i, gnt, mem_waddr, seq[i], i);
            end
            vectors++;
            if (mem_wdata !== req_data[exp_idx*DW +: DW]) begin
                errors++;
                $display("FAIL rotation_data_%0d: got %h want %h", i, mem_wdata, req_data[exp_idx*DW +: DW]);
            end
            adv();
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(NR'($urandom_range(1, 15)), 1'b0);
            #3;
            vectors++;
            if (gnt !== exp_gnt || mem_wen !== 1'b1 || mem_waddr !== PW'(i)) begin
                errors++;
                $display("FAIL fill_grant_%0d: gnt=%b wen=%b waddr=%0d want %b/1/%0d",
                         i, gnt, mem_wen, mem_waddr, exp_gnt, i);
            end
            adv();
            vectors++;
            if (wlevel !== (PW+1)'(i + 1) || wfull !== (i == 15) || walmost_full !== (i >= 13)) begin
                errors++;
                $display("FAIL fill_flags_%0d: level=%0d full=%b af=%b want %0d/%b/%b",
                         i, wlevel, wfull, walmost_full, i + 1, (i == 15), (i >= 13));
            end
        end
        vectors++;
        if (wptr_gray !== 5'b11000) begin
            errors++;
            $display("FAIL fill_gray: got %b want 11000", wptr_gray);
        end
        drive(4'b1111, 1'b0);
        #3;
        vectors++;
        if (gnt !== 4'b0000 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL fill_blocked: gnt=%b wen=%b want 0000/0", gnt, mem_wen);
        end
        adv();
    endtask

    task automatic test_drain();
        m_rbin = 1;
        drive('0, 1'b0);
        #3;
        adv();
        vectors++;
        if (wfull !== 1'b0 || wlevel !== 5'd15 || walmost_full !== 1'b1) begin
            errors++;
            $display("FAIL drain_flags: full=%b level=%0d af=%b want 0/15/1", wfull, wlevel, walmost_full);
        end
        drive(4'b1111, 1'b0);
        #3;
        vectors++;
        if (mem_wen !== 1'b1 || mem_waddr !== 4'd0 || gnt !== exp_gnt) begin
            errors++;
            $display("FAIL drain_grant: wen=%b waddr=%0d gnt=%b want 1/0/%b", mem_wen, mem_waddr, gnt, exp_gnt);
        end
        adv();
    endtask

    task automatic test_wrap();
        int          writes = 0;
        int          cycles = 0;
        logic        wrote;
        logic [PW:0] prev_g;
        do_reset();
        prev_g = wptr_gray;
        while (writes < 40 && cycles < 400) begin
            if (m_rbin != m_wbin && $urandom_range(0, 3) != 0) m_rbin = (m_rbin + 1) % 32;
            drive(($urandom_range(0, 3) != 0) ? NR'($urandom_range(1, 15)) : '0, 1'b0);
            #3;
            vectors++;
            if (gnt !== exp_gnt || mem_wen !== exp_wen || mem_waddr !== PW'(m_wbin)) begin
                errors++;
                $display("FAIL wrap_grant: gnt=%b wen=%b waddr=%0d want %b/%b/%0d",
                         gnt, mem_wen, mem_waddr, exp_gnt, exp_wen, m_wbin % 16);
            end
            wrote = exp_wen;
            if (exp_wen) writes++;
            adv();
            cycles++;
            vectors++;
            if (wlevel !== (PW+1)'(m_level) || wfull !== m_full || walmost_full !== m_af ||
                wptr_gray !== to_gray(m_wbin)) begin
                errors++;
                $display("FAIL wrap_flags: level=%0d full=%b af=%b gray=%b want %0d/%b/%b/%b",
                         wlevel, wfull, walmost_full, wptr_gray, m_level, m_full, m_af, to_gray(m_wbin));
            end
            vectors++;
            if ($countones(wptr_gray ^ prev_g) != (wrote ? 1 : 0)) begin
                errors++;
                $display("FAIL wrap_gray_step: prev=%b now=%b wrote=%b", prev_g, wptr_gray, wrote);
            end
            prev_g = wptr_gray;
        end
        vectors++;
        if (writes < 40) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes want 40 within budget", writes);
        end
    endtask

    task automatic test_random(input int ncyc);
        logic rst;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (rst) m_rbin = 0;
            else if (m_rbin != m_wbin && $urandom_range(0, 3) == 0) m_rbin = (m_rbin + 1) % 32;
            drive(NR'($urandom_range(0, 15)), rst);
            #3;
            vectors++;
            if (gnt !== exp_gnt || mem_wen !== exp_wen || mem_waddr !== PW'(m_wbin) ||
                (exp_wen && mem_wdata !== req_data[exp_idx*DW +: DW])) begin
                errors++;
                $display("FAIL random_grant: gnt=%b wen=%b waddr=%0d data=%h want %b/%b/%0d/%h",
                         gnt, mem_wen, mem_waddr, mem_wdata, exp_gnt, exp_wen, m_wbin % 16,
                         req_data[exp_idx*DW +: DW]);
            end
            adv();
            vectors++;
            if (wlevel !== (PW+1)'(m_level) || wfull !== m_full || walmost_full !== m_af ||
                wptr_gray !== to_gray(m_wbin)) begin
                errors++;
                $display("FAIL random_flags: level=%0d full=%b af=%b gray=%b want %0d/%b/%b/%b",
                         wlevel, wfull, walmost_full, wptr_gray, m_level, m_full, m_af, to_gray(m_wbin));
            end
        end
        wrst = 1'b0;
    endtask

    task automatic test_midburst_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0101, 1'b0);
            #3;
            vectors++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL burst_gnt_%0d: got %b want %b", i, gnt, exp_gnt);
            end
            adv();
        end
        drive(4'b0101, 1'b1);
        #3;
        vectors++;
        if (gnt !== 4'b0000 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL burst_rst_gnt: gnt=%b wen=%b want 0000/0", gnt, mem_wen);
        end
        adv();
        vectors++;
        if (wlevel !== 5'd0 || wptr_gray !== 5'd0 || wfull !== 1'b0 || mem_waddr !== 4'd0) begin
            errors++;
            $display("FAIL burst_rst_state: level=%0d gray=%b full=%b waddr=%0d want 0",
                     wlevel, wptr_gray, wfull, mem_waddr);
        end
        drive(4'b0101, 1'b0);
        #3;
        vectors++;
        if (gnt !== 4'b0001 || mem_waddr !== 4'd0) begin
            errors++;
            $display("FAIL burst_post_gnt: gnt=%b waddr=%0d want 0001/0", gnt, mem_waddr);
        end
        adv();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_fill();
        test_drain();
        test_wrap();
        test_random(300);
        test_midburst_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
